// File: rtl/enc_pkg.sv
// enc_pkg: shared state encoding and width helper for the priority encoder pipe
package enc_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/prio_enc_core.sv
// prio_enc_core: combinational N->W priority encoder
// vec: request vector; idx: winning bit (0 when none); none: no bit set; multi: more than one bit set
module prio_enc_core
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int MSB_FIRST = 1,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         none,
    output logic         multi
);
    // Scan from the losing end so the last hit is the winner.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (vec[(MSB_FIRST != 0) ? i : N - 1 - i])
                idx = W'((MSB_FIRST != 0) ? i : N - 1 - i);
    end
    assign none  = ~|vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - N'(1)));
endmodule

// File: rtl/prio_encoder_pipe.sv
// prio_encoder_pipe: valid/ready priority encoder with registered output and 2-entry skid buffer
// clk/rst: clock, sync active-high reset; in_valid/in_ready/in_data: input stream;
// out_valid/out_ready/out_idx/out_none: output stream; out_multi only with ENC_MULTI_CHK_EN
module prio_encoder_pipe
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int MSB_FIRST = 1,
    localparam int W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none
`ifdef ENC_MULTI_CHK_EN
    ,
    output logic         out_multi
`endif
);
`ifdef ENC_MULTI_CHK_EN
    localparam int EW = W + 2;
    logic enc_multi;
`else
    localparam int EW = W + 1;
    logic enc_multi_unused;
`endif
    logic [1:0]   state, state_nxt;
    logic [W-1:0] enc_idx;
    logic         enc_none, acc, con;
    logic [EW-1:0] enc, m, s;
    prio_enc_core #(.N(N), .MSB_FIRST(MSB_FIRST)) u_core (
        .vec  (in_data),
        .idx  (enc_idx),
        .none (enc_none),
`ifdef ENC_MULTI_CHK_EN
        .multi(enc_multi)
`else
        .multi(enc_multi_unused)
`endif
    );
    // Entries are stored already encoded: {multi?, none, idx}.
`ifdef ENC_MULTI_CHK_EN
    assign enc       = {enc_multi, enc_none, enc_idx};
    assign out_multi = m[W+1];
`else
    assign enc = {enc_none, enc_idx};
`endif
    assign {out_none, out_idx} = m[W:0];
    assign out_valid = state != ST_EMPTY;
    always_comb begin
        acc = in_valid && in_ready;
        con = out_valid && out_ready;
        state_nxt = (state == ST_EMPTY) ? (acc ? ST_ONE : ST_EMPTY) :
                    (state == ST_ONE)   ? ((acc && !con) ? ST_FULL : (!acc && con) ? ST_EMPTY : ST_ONE) :
                                          (con ? ST_ONE : ST_FULL);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
            m        <= '0;
            s        <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt != ST_FULL;
            // M takes a fresh vector when it is (or is becoming) free, otherwise drains S.
            if (acc && (state == ST_EMPTY || con))
                m <= enc;
            else if (state == ST_FULL && con)
                m <= s;
            if (acc && state == ST_ONE && !con)
                s <= enc;
        end
    end
endmodule
